poly_adsr_envelope: RTL
=======================

Name: poly_adsr_envelope

Overview:
- Polyphonic successor to the single-voice ADSR envelope and mixer pair.
- One time-multiplexed envelope engine keeps per-voice state and level for NUM_VOICES voices, with per-voice gates and legato retrigger.
- A tagged audio stream is scaled by the envelope of the voice it belongs to.
- Sits between the per-voice oscillator bank and the voice summer.

Parameters:
- NUM_VOICES, 8, number of voices; must be at least 2.
- DATA_WIDTH, 32, signed audio sample width.
- ENVELOPE_WIDTH, 32, unsigned envelope level width. ENV_MAX = 2^ENVELOPE_WIDTH - 1.
- RATE_WIDTH, 16, rate input width; must be no greater than ENVELOPE_WIDTH.
- TICK_DIV, 64, clock cycles between sweep starts; must be at least NUM_VOICES.
- VW, $clog2(NUM_VOICES), voice index width (localparam).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- note_on  in  NUM_VOICES  per-voice gate levels
- attack_rate  in  RATE_WIDTH  attack increment per update
- decay_rate  in  RATE_WIDTH  decay decrement per update
- sustain_percent  in  7  sustain level, 0-100; values above 100 are clamped to 100
- release_rate  in  RATE_WIDTH  release decrement per update
- audio_in  in  DATA_WIDTH  signed input sample
- audio_voice_in  in  VW  voice tag of audio_in
- data_in_valid  in  1  input sample qualifier
- audio_out  out  DATA_WIDTH  signed scaled sample
- audio_voice_out  out  VW  voice tag of audio_out
- data_out_valid  out  1  output sample qualifier
- voice_active  out  NUM_VOICES  bit v is 1 when voice v is not IDLE

Behaviour:
- Reset, asynchronous on rst_n low:
  - All levels 0 and all states IDLE.
  - Pending-rise flags, prescaler and sweep pointer cleared.
  - All outputs 0.
  - Reset mid-sweep or mid-pipeline discards all in-flight work.
- Prescaler:
  - Counts 0 to TICK_DIV-1 and wraps.
  - At count 0 a sweep starts: the pointer visits voices 0 to NUM_VOICES-1, one per cycle, then idles until the next sweep.
  - Each voice gets exactly one update per sweep.
- Gate edges:
  - note_on is registered every cycle.
  - A rising edge sets pending_rise[v], which is held until voice v is visited.
- Per-voice FSM, evaluated on visit. INC(r) = r << (ENVELOPE_WIDTH - RATE_WIDTH).
  - pending_rise set: go to ATTACK, keep the current level (no click), clear the flag. This takes priority over all rules below.
  - Gate low while in ATTACK, DECAY or SUSTAIN: go to RELEASE, keep the level.
  - IDLE: level = 0.
  - ATTACK: level += INC. If the sum reaches or exceeds ENV_MAX, or attack_rate = 0: level = ENV_MAX and go to DECAY.
  - DECAY: level -= INC. If the result is at or below SUS, or decay_rate = 0: level = SUS and go to SUSTAIN.
  - SUSTAIN: level = SUS, tracking live changes to sustain_percent.
  - RELEASE: level -= INC. If the result underflows or reaches 0, or release_rate = 0: level = 0 and go to IDLE.
- Sustain level:
  - SUS = min(sustain_percent, 100) × floor(ENV_MAX / 100).
  - Exception: sustain_percent of 100 or more gives SUS = ENV_MAX.
- voice_active is registered and updates in the cycle after a visit changes a voice's state.
- Mixer pipeline, 2-cycle latency, no backpressure, accepts one sample per cycle:
  - Stage 1 registers the sample and tag, and reads level[audio_voice_in] from the register array.
  - If a sweep writes the same voice in that cycle, the pre-write level is used.
  - Stage 2: audio_out = (audio_in × {1'b0, level}) >>> ENVELOPE_WIDTH, with a signed full-width product, arithmetic shift, truncated to DATA_WIDTH.
  - data_out_valid is data_in_valid delayed by 2 cycles; audio_voice_out is the tag delayed identically.
  - audio_out and audio_voice_out hold their value when data_out_valid is low.
  - A tag of NUM_VOICES or more (non-power-of-2 counts) scales by 0.

Test Plan (NUM_VOICES=4, TICK_DIV=4, ENVELOPE_WIDTH=32, RATE_WIDTH=16):
- Attack: rise on note_on[2] with attack_rate=0x4000.
  - Level[2] reads 0x40000000, 0x80000000, 0xC00000 00 on successive updates, i.e. 0x40000000, 0x80000000, 0xC0000000.
  - The 4th update gives 0xFFFFFFFF and DECAY; voice_active=4'b0100.
- Sustain: sustain_percent=50, decay_rate=0xFFFF.
  - The next update lands on level 2147483600 in SUSTAIN.
  - Changing to sustain_percent=127 gives 0xFFFFFFFF on the next update.
- Release: gate low in SUSTAIN with release_rate=0.
  - The next visit gives RELEASE; the following visit gives level 0 and IDLE; voice_active bit clears.
- Retrigger: rise during RELEASE at level 0x30000000.
  - The next visit gives ATTACK from 0x30000000, not 0.
  - A rise then fall within one sweep gives ATTACK, then RELEASE on the following visit.
- Mixer: voice at ENV_MAX.
  - audio_in=1000 gives audio_out=999 exactly 2 cycles later; -1000 gives -1000.
  - An IDLE voice gives 0.
  - Back-to-back samples for voices 0-3 produce 4 consecutive valid outputs with the tags preserved.
- Reset: assert rst_n low mid-attack with valid in flight.
  - All outputs 0 immediately; after release, the voices stay IDLE until new rising edges.

Source files
------------

// File: rtl/poly_adsr_envelope.sv
// poly_adsr_envelope
//   Time-multiplexed ADSR envelope engine for NUM_VOICES voices, followed by a
//   two-stage mixer that scales a voice-tagged audio stream by the envelope
//   level of the voice it belongs to.
//
//   A prescaler starts a sweep every TICK_DIV cycles. During the first
//   NUM_VOICES cycles of each period, one voice per cycle is visited, and its
//   state and level are updated.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   note_on[NUM_VOICES]          per-voice gate levels
//   attack/decay/release_rate    per-update increment/decrement (upper bits of level)
//   sustain_percent              sustain level 0-100 (clamped above 100)
//   audio_in, audio_voice_in,
//   data_in_valid                tagged input sample
//   audio_out, audio_voice_out,
//   data_out_valid               scaled sample, 2 cycles after input
//   voice_active[NUM_VOICES]     voice is not IDLE
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | silent, level held at 0
// ATTACK   | level rising by attack increment toward ENV_MAX
// DECAY    | level falling by decay decrement toward sustain
// SUSTAIN  | level tracks live sustain setting while gate high
// RELEASE  | level falling by release decrement toward 0
module poly_adsr_envelope #(
   parameter int NUM_VOICES     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int ENVELOPE_WIDTH = 32,
   parameter int RATE_WIDTH     = 16,
   parameter int TICK_DIV       = 64,
   localparam int VW            = $clog2(NUM_VOICES)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_VOICES-1:0]  note_on,
   input  logic [RATE_WIDTH-1:0]  attack_rate,
   input  logic [RATE_WIDTH-1:0]  decay_rate,
   input  logic [6:0]             sustain_percent,
   input  logic [RATE_WIDTH-1:0]  release_rate,
   input  logic [DATA_WIDTH-1:0]  audio_in,
   input  logic [VW-1:0]          audio_voice_in,
   input  logic                   data_in_valid,
   output logic [DATA_WIDTH-1:0]  audio_out,
   output logic [VW-1:0]          audio_voice_out,
   output logic                   data_out_valid,
   output logic [NUM_VOICES-1:0]  voice_active
);

   localparam int EW = ENVELOPE_WIDTH;
   localparam int DW = DATA_WIDTH;
   // One extra bit so that NUM_VOICES == TICK_DIV still compares correctly.
   localparam int PW = $clog2(TICK_DIV) + 1;
   localparam logic [EW-1:0] ENV_MAX  = '1;
   localparam logic [EW-1:0] SUS_STEP = ENV_MAX / EW'(100);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } env_state_t;

   env_state_t              st [NUM_VOICES];
   logic [EW-1:0]           lvl [NUM_VOICES];

   logic [PW-1:0]           presc;
   logic                    visit;
   logic [VW-1:0]           ptr;
   logic [NUM_VOICES-1:0]   note_q;
   logic [NUM_VOICES-1:0]   pending;
   logic [NUM_VOICES-1:0]   rise;
   logic [NUM_VOICES-1:0]   clr;

   env_state_t              cur_st, nxt_st;
   logic [EW-1:0]           cur_lvl, nxt_lvl, inc, sus;
   logic [RATE_WIDTH-1:0]   rate;
   logic [EW:0]             sum, diff;
   logic                    gate, pend;

   // The sweep pointer is the low bits of the prescaler during the sweep window.
   assign visit = presc < PW'(NUM_VOICES);
   assign ptr   = presc[VW-1:0];
   assign rise  = note_on & ~note_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (presc == PW'(TICK_DIV - 1)) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   always_comb begin
      clr = '0;
      if (visit) clr[ptr] = 1'b1;
   end

   // A rise arriving in the same cycle as the visit survives to the next sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         note_q  <= '0;
         pending <= '0;
      end else begin
         note_q  <= note_on;
         pending <= (pending & ~clr) | rise;
      end
   end

   always_comb begin
      if (sustain_percent >= 7'd100) sus = ENV_MAX;
      else                           sus = SUS_STEP * EW'(sustain_percent);
   end

   always_comb begin
      cur_st  = st[ptr];
      cur_lvl = lvl[ptr];
      gate    = note_q[ptr];
      pend    = pending[ptr];
      rate    = '0;
      case (cur_st)
         S_ATTACK:  rate = attack_rate;
         S_DECAY:   rate = decay_rate;
         S_RELEASE: rate = release_rate;
         default:   rate = '0;
      endcase
      inc     = EW'(rate) << (EW - RATE_WIDTH);
      sum     = {1'b0, cur_lvl} + {1'b0, inc};
      diff    = {1'b0, cur_lvl} - {1'b0, inc};
      nxt_st  = cur_st;
      nxt_lvl = cur_lvl;
      if (pend) begin
         nxt_st = S_ATTACK;
      end else if (!gate && (cur_st == S_ATTACK || cur_st == S_DECAY ||
                             cur_st == S_SUSTAIN)) begin
         nxt_st = S_RELEASE;
      end else begin
         case (cur_st)
            S_IDLE: nxt_lvl = '0;
            S_ATTACK: begin
               if (sum[EW] || (&sum[EW-1:0]) || rate == '0) begin
                  nxt_lvl = ENV_MAX;
                  nxt_st  = S_DECAY;
               end else begin
                  nxt_lvl = sum[EW-1:0];
               end
            end
            S_DECAY: begin
               if (diff[EW] || diff[EW-1:0] <= sus || rate == '0) begin
                  nxt_lvl = sus;
                  nxt_st  = S_SUSTAIN;
               end else begin
                  nxt_lvl = diff[EW-1:0];
               end
            end
            S_SUSTAIN: nxt_lvl = sus;
            S_RELEASE: begin
               if (diff[EW] || diff[EW-1:0] == '0 || rate == '0) begin
                  nxt_lvl = '0;
                  nxt_st  = S_IDLE;
               end else begin
                  nxt_lvl = diff[EW-1:0];
               end
            end
            default: begin
               nxt_lvl = '0;
               nxt_st  = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            st[v]  <= S_IDLE;
            lvl[v] <= '0;
         end
         voice_active <= '0;
      end else if (visit) begin
         st[ptr]           <= nxt_st;
         lvl[ptr]          <= nxt_lvl;
         voice_active[ptr] <= (nxt_st != S_IDLE);
      end
   end

   // Mixer. Stage 1 reads the level register before any same-cycle sweep write.
   logic                  s1_valid;
   logic [DW-1:0]         s1_data;
   logic [VW-1:0]         s1_tag;
   logic [EW-1:0]         s1_lvl;
   logic [EW-1:0]         tag_lvl;
   logic signed [DW+EW-1:0] prod;
   logic [DW-1:0]         scaled;
   logic [EW-1:0]         prod_frac_unused;

   always_comb begin
      tag_lvl = '0;
      if ({1'b0, audio_voice_in} < (VW+1)'(NUM_VOICES)) tag_lvl = lvl[audio_voice_in];
   end

   // Level is zero-extended so ENV_MAX stays positive; the product always fits DW+EW bits.
   assign prod = $signed(s1_data) * $signed({1'b0, s1_lvl});
   assign {scaled, prod_frac_unused} = prod;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid        <= 1'b0;
         s1_data         <= '0;
         s1_tag          <= '0;
         s1_lvl          <= '0;
         data_out_valid  <= 1'b0;
         audio_out       <= '0;
         audio_voice_out <= '0;
      end else begin
         s1_valid       <= data_in_valid;
         data_out_valid <= s1_valid;
         if (data_in_valid) begin
            s1_data <= audio_in;
            s1_tag  <= audio_voice_in;
            s1_lvl  <= tag_lvl;
         end
         if (s1_valid) begin
            audio_out       <= scaled;
            audio_voice_out <= s1_tag;
         end
      end
   end

endmodule
